conv_sequencer: RTL and testbench

Controller that sequences the waveform ROM and Gaussian-kernel ROM through a 1-D 8-tap convolution, independent of the instruction stream. Accepts a start command with base sample address and output count. Walks the tap and sample counters, accumulates products, and emits one normalised 8-bit filtered sample per window over a valid/ready handshake. Sits beside `cpu`, driving its own read ports of `w_rom` (D=8, A=8) and `g_rom` (D=8, A=3). Both ROMs are combinational-read.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_mac.sv | 42 ++++
 rtl/conv_sequencer.sv | 136 +++++++++++++
 tb/tb_conv_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, state encoding and the saturating normalise used by the
// 8-tap convolution sequencer.
package conv_pkg;

  localparam int unsigned D_W   = 8;
  localparam int unsigned A_W   = 8;
  localparam int unsigned TAPS  = 8;
  localparam int unsigned TAP_W = 3;
  localparam int unsigned ACC_W = 2 * D_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Keep the upper product byte; any bit above the 2D-bit product range means overflow.
  function automatic logic [D_W-1:0] sat_norm(input logic [ACC_W-1:0] acc);
    if (acc[ACC_W-1:2*D_W] != '0) begin
      return '1;
    end
    return acc[2*D_W-1:D_W];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate register for one convolution window, with a registered
// saturating normalise of the completed sum.
module conv_mac
  import conv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           en,
  input  logic           load,
  input  logic [D_W-1:0] sample,
  input  logic [D_W-1:0] coeff,
  output logic [D_W-1:0] norm
);

  logic [ACC_W-1:0]   acc;
  logic [2*D_W-1:0]   prod_c;
  logic [ACC_W-1:0]   sum_c;

  assign prod_c = sample * coeff;
  assign sum_c  = acc + ACC_W'(prod_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_c;
    end
  end

  // Captured on the last tap so the result includes the final product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      norm <= '0;
    end else if (load) begin
      norm <= sat_norm(sum_c);
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Walks the wave and kernel ROMs through an 8-tap convolution per output
// window and hands each normalised result out over valid/ready.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned D = D_W,
  parameter int unsigned A = A_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [A-1:0]     base_addr,
  input  logic [A-1:0]     num_out,
  output logic [A-1:0]     wave_addr,
  input  logic [D-1:0]     wave_data,
  output logic [TAP_W-1:0] kern_addr,
  input  logic [D-1:0]     gaus_data,
  output logic [D-1:0]     result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             done
);

  state_t            state, state_n;
  logic [A-1:0]      base_q, base_n;
  logic [A-1:0]      cnt_q, cnt_n;
  logic [A-1:0]      idx_q, idx_n;
  logic [TAP_W-1:0]  tap_q, tap_n;
  logic              mac_clr, mac_en, mac_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    base_n   = base_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    tap_n    = tap_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    mac_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_out != '0) begin
            base_n  = base_addr;
            cnt_n   = num_out;
            idx_n   = '0;
            tap_n   = '0;
            mac_clr = 1'b1;
            state_n = ACCUM;
          end else begin
            state_n = DONE;
          end
        end
      end
      ACCUM: begin
        mac_en = 1'b1;
        if (tap_q == TAP_W'(TAPS - 1)) begin
          mac_load = 1'b1;
          state_n  = EMIT;
        end else begin
          tap_n = tap_q + TAP_W'(1);
        end
      end
      EMIT: begin
        if (result_ready) begin
          if (idx_q == cnt_q - A'(1)) begin
            state_n = DONE;
          end else begin
            idx_n   = idx_q + A'(1);
            tap_n   = '0;
            mac_clr = 1'b1;
            state_n = ACCUM;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Cancel wins over any in-flight transition once a job is under way.
    if (abort && (state != IDLE)) begin
      state_n  = IDLE;
      mac_load = 1'b0;
    end
  end

  // Outputs are registered decodes of the next state so nothing reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      tap_q        <= '0;
      wave_addr    <= '0;
      kern_addr    <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      base_q       <= base_n;
      cnt_q        <= cnt_n;
      idx_q        <= idx_n;
      tap_q        <= tap_n;
      wave_addr    <= (state_n == ACCUM) ? (base_n + idx_n + A'(tap_n)) : '0;
      kern_addr    <= (state_n == ACCUM) ? tap_n : '0;
      result_valid <= (state_n == EMIT);
      busy         <= (state_n == ACCUM) || (state_n == EMIT);
      done         <= (state_n == DONE);
    end
  end

  conv_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .load   (mac_load),
    .sample (wave_data),
    .coeff  (gaus_data),
    .norm   (result)
  );

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: ROM models, expected results queued at
// start and compared at each handshake, plus timing, wrap, stall, abort and reset cases.
`timescale 1ns/1ps
module tb_conv_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] base_addr, num_out;
  logic [7:0] wave_addr, wave_data;
  logic [2:0] kern_addr;
  logic [7:0] gaus_data, result;
  logic       result_valid, result_ready, busy, done;

  logic [7:0] wave_mem [256];
  logic [7:0] gaus_mem [8];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         vcyc[$];
  logic [7:0] addr_log[$];
  logic [2:0] kern_log[$];
  int         done_cyc;

  always #5 clk = ~clk;

  assign wave_data = wave_mem[wave_addr];
  assign gaus_data = gaus_mem[kern_addr];

  conv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .num_out      (num_out),
    .wave_addr    (wave_addr),
    .wave_data    (wave_data),
    .kern_addr    (kern_addr),
    .gaus_data    (gaus_data),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] base, input logic [7:0] idx);
    int unsigned acc;
    logic [7:0]  a;
    acc = 0;
    for (int t = 0; t < 8; t++) begin
      a = base + idx + 8'(t);
      acc += 32'(wave_mem[a]) * 32'(gaus_mem[t]);
    end
    return (acc > 32'hFFFF) ? 8'hFF : 8'(acc >> 8);
  endfunction

  // Run one job from the current sample point; stall = ready-low cycles per result.
  task automatic run_job(input logic [7:0] base, input logic [7:0] cnt,
                         input int stall, input bit poke);
    int         cyc;
    int         stall_left;
    logic [7:0] held;
    bit         prev_valid;
    vcyc.delete();
    addr_log.delete();
    kern_log.delete();
    done_cyc = -1;
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(model(base, 8'(i)));
    start = 1'b1; base_addr = base; num_out = cnt;
    @(posedge clk); #1;
    start = 1'b0; num_out = 8'd0;
    cyc = 1; prev_valid = 1'b0; stall_left = 0; held = '0;
    while (cyc < 400) begin
      if (poke && cyc == 3) begin
        start = 1'b1; base_addr = 8'h55; num_out = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (busy && !result_valid) begin
        addr_log.push_back(wave_addr);
        kern_log.push_back(kern_addr);
      end
      if (result_valid) begin
        if (!prev_valid) begin
          vcyc.push_back(cyc);
          stall_left = stall;
          held = result;
        end else begin
          check("hold_result", 32'(result), 32'(held));
        end
        if (stall_left > 0) begin
          result_ready = 1'b0;
          stall_left--;
          check("stall_busy", 32'(busy), 32'd1);
        end else begin
          result_ready = 1'b1;
          if (exp_q.size() == 0) check("extra_result", 32'(result_valid), 32'd0);
          else check("result", 32'(result), 32'(exp_q.pop_front()));
        end
      end else begin
        result_ready = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        check("done_busy_low", 32'(busy), 32'd0);
        break;
      end
      prev_valid = result_valid;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    result_ready = 1'b1;
    if (done_cyc < 0) begin
      check("done_timeout", 32'(cyc), 32'd0);
    end else begin
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    check("results_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    int k;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; num_out = '0; result_ready = 1'b1;
    for (int i = 0; i < 256; i++) wave_mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) gaus_mem[i] = 8'h00;
    #12;
    check("rst_wave_addr", 32'(wave_addr), 32'd0);
    check("rst_kern_addr", 32'(kern_addr), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Unity gain: 8 * 0x10 * 0x20 = 0x1000 -> 0x10
    for (int i = 0; i < 256; i++) wave_mem[i] = 8'h10;
    for (int i = 0; i < 8; i++) gaus_mem[i] = 8'h20;
    run_job(8'h00, 8'd3, 0, 1'b0);
    check("unity_nvalid", 32'(vcyc.size()), 32'd3);
    if (vcyc.size() == 3) begin
      check("unity_valid0_cyc", 32'(vcyc[0]), 32'd9);
      check("unity_valid1_cyc", 32'(vcyc[1]), 32'd18);
      check("unity_valid2_cyc", 32'(vcyc[2]), 32'd27);
    end
    check("unity_done_cyc", 32'(done_cyc), 32'd28);

    // Saturation
    for (int i = 0; i < 256; i++) wave_mem[i] = 8'hFF;
    for (int i = 0; i < 8; i++) gaus_mem[i] = 8'hFF;
    run_job(8'h00, 8'd1, 0, 1'b0);
    check("sat_done_cyc", 32'(done_cyc), 32'd10);

    // Wrap-around, with a start strobe while busy that must be ignored
    for (int i = 0; i < 256; i++) wave_mem[i] = 8'(i * 37 + 11);
    gaus_mem[0] = 8'd8;  gaus_mem[1] = 8'd16; gaus_mem[2] = 8'd32; gaus_mem[3] = 8'd64;
    gaus_mem[4] = 8'd64; gaus_mem[5] = 8'd32; gaus_mem[6] = 8'd16; gaus_mem[7] = 8'd8;
    run_job(8'hFE, 8'd1, 0, 1'b1);
    check("wrap_naddr", 32'(addr_log.size()), 32'd8);
    if (addr_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("wrap_addr%0d", i), 32'(addr_log[i]), 32'(8'(8'hFE + 8'(i))));
        check($sformatf("wrap_kern%0d", i), 32'(kern_log[i]), 32'(i));
      end
    end
    check("busy_start_ignored_done", 32'(done_cyc), 32'd10);

    // Backpressure: ready low for 5 cycles at each result
    run_job(8'h40, 8'd2, 5, 1'b0);
    check("stall_nvalid", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) begin
      check("stall_valid0_cyc", 32'(vcyc[0]), 32'd9);
      check("stall_valid1_cyc", 32'(vcyc[1]), 32'd23);
    end
    check("stall_done_cyc", 32'(done_cyc), 32'd29);

    // Multi-output window crossing the address wrap, short stall
    run_job(8'hFC, 8'd4, 1, 1'b0);
    check("multi_nvalid", 32'(vcyc.size()), 32'd4);

    // Zero count
    run_job(8'h00, 8'd0, 0, 1'b0);
    check("zero_done_cyc", 32'(done_cyc), 32'd1);
    check("zero_nvalid", 32'(vcyc.size()), 32'd0);

    // Abort in ACCUM cycle 4
    start = 1'b1; base_addr = 8'h00; num_out = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || result_valid || busy) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Asynchronous reset while in EMIT
    start = 1'b1; base_addr = 8'h00; num_out = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; result_ready = 1'b0;
    k = 0;
    while (!result_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("rst_reach_emit", 32'(result_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_wave_addr", 32'(wave_addr), 32'd0);
    check("arst_kern_addr", 32'(kern_addr), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; result_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", 32'(done), 32'd0);
    run_job(8'h10, 8'd2, 0, 1'b0);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd19);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
